// File: rtl/button_pkg.sv
// Shared definitions for the pushbutton debouncer: state encoding and
// board-level timing defaults for the 50 MHz clock.
package button_pkg;

  localparam int CLK_HZ = 50_000_000;

  // 20 ms of stable input accepts a change, 1 s of hold raises the long pulse.
  localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;
  localparam int DEF_LONG_CYCLES     = CLK_HZ;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; the reset value lets
// each input start at its own inactive level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from the same edge instead of collapsing into one stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/button_debouncer.sv
// Turns a raw bouncing pushbutton into a debounced level plus one-cycle
// press, release and long-press pulses, all registered.
module button_debouncer
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic CLK50,
  input  logic RESET_N,
  input  logic BTN,
  output logic PRESSED,
  output logic PRESS_PULSE,
  output logic RELEASE_PULSE,
  output logic LONG_PULSE
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  logic              w_btn_sync;
  logic              w_btn_s;

  state_e            r_state;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_pressed;
  logic              r_press_pulse;
  logic              r_release_pulse;
  logic              r_long_pulse;

  state_e            w_state_nxt;
  logic [DEB_W-1:0]  w_deb_cnt_nxt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;
  logic [HOLD_W-1:0] w_hold_inc;
  logic              w_pressed_nxt;
  logic              w_press_pulse_nxt;
  logic              w_release_pulse_nxt;
  logic              w_long_pulse_nxt;

  // Reset loads the released raw level so reset release never looks like a press.
  sync_2ff #(
    .RESET_VAL (BTN_ACTIVE_LOW)
  ) u_btn_sync (
    .i_clk   (CLK50),
    .i_rst_n (RESET_N),
    .i_d     (BTN),
    .o_q     (w_btn_sync)
  );

  assign w_btn_s    = BTN_ACTIVE_LOW ? ~w_btn_sync : w_btn_sync;
  assign w_hold_inc = (r_hold_cnt == HOLD_MAX) ? r_hold_cnt
                                               : r_hold_cnt + HOLD_W'(1);

  always_ff @(posedge CLK50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state         <= IDLE;
      r_deb_cnt       <= '0;
      r_hold_cnt      <= '0;
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_deb_cnt       <= w_deb_cnt_nxt;
      r_hold_cnt      <= w_hold_cnt_nxt;
      r_pressed       <= w_pressed_nxt;
      r_press_pulse   <= w_press_pulse_nxt;
      r_release_pulse <= w_release_pulse_nxt;
      r_long_pulse    <= w_long_pulse_nxt;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_deb_cnt_nxt  = r_deb_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      IDLE: begin
        if (w_btn_s) begin
          w_state_nxt   = PRESS_CHK;
          w_deb_cnt_nxt = '0;
        end
      end
      PRESS_CHK: begin
        if (!w_btn_s) begin
          w_state_nxt = IDLE;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt    = HELD;
          w_hold_cnt_nxt = '0;
        end else begin
          w_deb_cnt_nxt = r_deb_cnt + DEB_W'(1);
        end
      end
      HELD: begin
        w_hold_cnt_nxt = w_hold_inc;
        if (!w_btn_s) begin
          w_state_nxt   = RELEASE_CHK;
          w_deb_cnt_nxt = '0;
        end
      end
      RELEASE_CHK: begin
        // Hold time keeps accumulating so a bounced release does not restart it.
        w_hold_cnt_nxt = w_hold_inc;
        if (w_btn_s) begin
          w_state_nxt = HELD;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_deb_cnt_nxt = r_deb_cnt + DEB_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output decode works on transitions, so each pulse is one registered cycle.
  always_comb begin
    w_pressed_nxt       = (w_state_nxt == HELD) || (w_state_nxt == RELEASE_CHK);
    w_press_pulse_nxt   = (r_state == PRESS_CHK)   && (w_state_nxt == HELD);
    w_release_pulse_nxt = (r_state == RELEASE_CHK) && (w_state_nxt == IDLE);
    w_long_pulse_nxt    = (r_state == HELD)        && (r_hold_cnt == HOLD_LAST);
  end

  assign PRESSED       = r_pressed;
  assign PRESS_PULSE   = r_press_pulse;
  assign RELEASE_PULSE = r_release_pulse;
  assign LONG_PULSE    = r_long_pulse;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: stimulus queues the expected pulse and
// edge, an independent monitor matches every pulse the DUT produces.
module tb_button_debouncer;

  localparam int DEB = 4;
  localparam int LNG = 20;

  logic CLK50 = 1'b0;
  logic RESET_N;
  logic BTN;
  logic PRESSED;
  logic PRESS_PULSE;
  logic RELEASE_PULSE;
  logic LONG_PULSE;

  typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_LONG = 2} ev_e;
  typedef struct {
    ev_e kind;
    int  edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LNG),
    .BTN_ACTIVE_LOW  (1'b1)
  ) dut (
    .CLK50         (CLK50),
    .RESET_N       (RESET_N),
    .BTN           (BTN),
    .PRESSED       (PRESSED),
    .PRESS_PULSE   (PRESS_PULSE),
    .RELEASE_PULSE (RELEASE_PULSE),
    .LONG_PULSE    (LONG_PULSE)
  );

  always #10 CLK50 = ~CLK50;

  always @(posedge CLK50) edge_cnt++;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp_v, edge_cnt);
    end
  endtask

  // Called on the negedge where BTN changes: the next posedge is edge 0.
  task automatic expect_ev(input ev_e k, input int lat);
    exp_t e;
    e.kind   = k;
    e.edge_n = edge_cnt + 1 + lat;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK50);
  endtask

  always @(negedge CLK50) begin : monitor
    int   n;
    ev_e  k;
    exp_t e;
    n = int'(PRESS_PULSE) + int'(RELEASE_PULSE) + int'(LONG_PULSE);
    if (n > 1) begin
      check("pulse_exclusive", n, 1);
    end else if (n == 1) begin
      k = PRESS_PULSE ? EV_PRESS : (RELEASE_PULSE ? EV_RELEASE : EV_LONG);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: got %s at edge %0d, expected none", k.name(), edge_cnt);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", k, e.kind);
        check("pulse_edge", edge_cnt, e.edge_n);
        check("pressed_with_pulse", int'(PRESSED), (k == EV_RELEASE) ? 0 : 1);
      end
    end else if (exp_q.size() > 0 && exp_q[0].edge_n < edge_cnt) begin
      e = exp_q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL missed_pulse: got nothing, expected %s at edge %0d", e.kind.name(), e.edge_n);
    end
  end

  initial begin
    RESET_N = 1'b0;
    BTN     = 1'b1;
    cycles(3);
    check("reset_pressed", int'(PRESSED), 0);
    check("reset_press_pulse", int'(PRESS_PULSE), 0);
    check("reset_release_pulse", int'(RELEASE_PULSE), 0);
    check("reset_long_pulse", int'(LONG_PULSE), 0);
    RESET_N = 1'b1;
    cycles(10);
    check("idle_after_reset", int'(PRESSED), 0);

    // Clean press: PRESSED rises after edge DEB+2.
    BTN = 1'b0;
    expect_ev(EV_PRESS, DEB + 2);
    cycles(DEB + 2);
    check("press_not_yet", int'(PRESSED), 0);
    cycles(1);
    check("press_level", int'(PRESSED), 1);

    // Release with bounce: high 2, low 1, then high steady.
    BTN = 1'b1;
    cycles(2);
    BTN = 1'b0;
    cycles(1);
    BTN = 1'b1;
    expect_ev(EV_RELEASE, DEB + 2);
    cycles(DEB + 2);
    check("release_not_yet", int'(PRESSED), 1);
    cycles(1);
    check("release_level", int'(PRESSED), 0);
    cycles(10);

    // Bounce rejection: low runs too short to qualify.
    BTN = 1'b0;
    cycles(3);
    BTN = 1'b1;
    cycles(2);
    BTN = 1'b0;
    cycles(3);
    BTN = 1'b1;
    cycles(15);
    check("bounce_rejected", int'(PRESSED), 0);

    // Long press: LONG 20 cycles after PRESS, then a normal release.
    BTN = 1'b0;
    expect_ev(EV_PRESS, DEB + 2);
    expect_ev(EV_LONG, DEB + 2 + LNG);
    cycles(DEB + 3 + 30);
    check("long_hold_level", int'(PRESSED), 1);
    BTN = 1'b1;
    expect_ev(EV_RELEASE, DEB + 2);
    cycles(DEB + 3);
    check("long_release_level", int'(PRESSED), 0);
    cycles(5);

    // Short press: no LONG pulse.
    BTN = 1'b0;
    expect_ev(EV_PRESS, DEB + 2);
    cycles(10);
    BTN = 1'b1;
    expect_ev(EV_RELEASE, DEB + 2);
    cycles(DEB + 3 + LNG);
    check("short_release_level", int'(PRESSED), 0);

    // Reset while in RELEASE_CHK, button held low through reset release.
    BTN = 1'b0;
    expect_ev(EV_PRESS, DEB + 2);
    cycles(DEB + 4);
    BTN = 1'b1;
    cycles(4);
    check("relchk_still_pressed", int'(PRESSED), 1);
    BTN     = 1'b0;
    RESET_N = 1'b0;
    #1;
    check("async_reset_pressed", int'(PRESSED), 0);
    check("async_reset_press_pulse", int'(PRESS_PULSE), 0);
    check("async_reset_release_pulse", int'(RELEASE_PULSE), 0);
    check("async_reset_long_pulse", int'(LONG_PULSE), 0);
    cycles(3);
    RESET_N = 1'b1;
    expect_ev(EV_PRESS, DEB + 2);
    cycles(DEB + 3);
    check("held_through_reset", int'(PRESSED), 1);
    BTN = 1'b1;
    expect_ev(EV_RELEASE, DEB + 2);
    cycles(DEB + 3);
    check("final_release_level", int'(PRESSED), 0);
    cycles(5);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
